fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle datapath. It owns the PC register, issues requests to instruction memory over a request/response handshake, and holds the returned word. It presents instr, pc and next_pc (pc+4) to the datapath and control, and applies the branch/jump redirect when the core consumes an instruction. A retired-instruction counter is included for bring-up.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset; must be 4-byte aligned.

Ports:
clk            input   1   system clock, rising edge
rst_n          input   1   asynchronous active-low reset
imem_req       output  1   fetch request valid
imem_addr      output  32  fetch address; equals pc
imem_ready     input   1   memory accepts request this cycle (imem_req & imem_ready)
imem_rvalid    input   1   response data valid
imem_rdata     input   32  response instruction word
instr          output  32  held instruction to datapath
pc             output  32  address of instr
next_pc        output  32  pc + 4, used for the JAL/JALR writeback mux in the datapath
instr_valid    output  1   instr/pc/next_pc are valid
instr_ready    input   1   core consumes instr this cycle
redirect       input   1   taken branch/jump; sampled only on consume
redirect_pc    input   32  target address
fetch_fault    output  1   sticky misaligned-target fault
retired_count  output  32  count of consumed instructions

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), retired_count=0. All control outputs (imem_req, instr_valid, fetch_fault) are 0. Reset mid-operation abandons any outstanding request. Instruction memory shares rst_n.
- FSM states: IDLE, REQ, WAIT, VALID, FAULT.
- IDLE: goes to REQ the next cycle. Used once after reset.
- REQ: imem_req=1, imem_addr=pc. On imem_ready, go to WAIT. Otherwise hold; addr stays stable while req is high.
- WAIT: imem_req=0. On imem_rvalid, capture instr<=imem_rdata and go to VALID. rvalid is never expected in the acceptance cycle; rvalid in any state other than WAIT is ignored.
- VALID: instr_valid=1. instr, pc and next_pc are held stable until consumed. Consume = instr_valid & instr_ready. On consume:
  - retired_count increments by 1, wrapping 32'hFFFF_FFFF to 0.
  - If redirect=0: pc<=pc+4 and go to REQ.
  - If redirect=1 and redirect_pc[1:0]==0: pc<=redirect_pc and go to REQ.
  - If redirect=1 and redirect_pc[1:0]!=0: pc<=redirect_pc, fetch_fault<=1, go to FAULT.
  - redirect is ignored when there is no consume.
- FAULT: imem_req=0, instr_valid=0, fetch_fault=1. Exits only via reset.
- next_pc = pc + 4 (combinational, 32-bit, wraps 32'hFFFF_FFFC to 32'h0000_0000). pc+4 wrap is legal and not a fault.
- Throughput with zero-wait memory (ready=1, rvalid one cycle after acceptance): 3 cycles per instruction (REQ, WAIT, VALID with ready=1). The VALID->REQ transition takes effect the cycle after consume; imem_addr then shows the updated pc.
- Outputs are registered or decoded from state/pc only. There is no combinational path from instr_ready/redirect to imem_req or imem_addr.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, memory returns 0x00500093, 0x00a00113 with ready=1 and rvalid next cycle, instr_ready=1 -> imem_addr 0 at cycle 1, 4 at cycle 4; instr_valid pulses at cycles 3 and 6; next_pc=4 then 8; retired_count=2.
- Backpressure on both sides: imem_ready low for 3 cycles, then rvalid delayed 2 cycles, then instr_ready low for 4 cycles -> imem_addr stays stable throughout; instr/pc stay stable while instr_valid=1; retired_count changes only on consume.
- Redirect: consume at pc=0x10 with redirect=1, redirect_pc=0x100 -> next imem_addr=0x100, next_pc=0x104. redirect=1 without instr_ready -> no pc change.
- Misaligned target: consume with redirect_pc=0x102 -> fetch_fault=1, pc=0x102, imem_req stays 0 for 20 cycles. Then assert rst_n=0 -> fault clears and pc=RESET_PC.
- Reset mid-WAIT: drop rst_n while in WAIT, then inject a stray rvalid during IDLE/REQ -> rvalid is ignored; the first instr captured is the response to the fresh request at RESET_PC.
- Wrap: RESET_PC=32'hFFFF_FFFC -> next_pc=0; after consume imem_addr=0. Preload retired_count to 32'hFFFF_FFFF via force -> wraps to 0 on the next consume.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/rsp handshake and
// holds the returned word until the core consumes it.
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | imem_req high, imem_addr = pc, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// VALID | instr/pc/next_pc presented, waiting for instr_ready
// FAULT | misaligned redirect target taken; only reset leaves
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic        consume;
  logic        misaligned;

  assign consume    = (state_q == S_VALID) && instr_ready;
  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (imem_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_VALID;
      S_VALID: if (consume) state_d = misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Redirect is only meaningful on consume; otherwise pc is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      retired_q <= 32'h0000_0000;
    end else begin
      if (consume) begin
        pc_q      <= redirect ? redirect_pc : pc_q + 32'd4;
        retired_q <= retired_q + 32'd1;
      end
      if ((state_q == S_WAIT) && imem_rvalid) begin
        instr_q <= imem_rdata;
      end
    end
  end

  always_comb begin
    imem_req    = (state_q == S_REQ);
    instr_valid = (state_q == S_VALID);
    fetch_fault = (state_q == S_FAULT);
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign next_pc       = pc_q + 32'd4;
  assign instr         = instr_q;
  assign retired_count = retired_q;

endmodule
